ahbl_sync_sram_slave: RTL
=========================

// Module: ahbl_sync_sram_slave
// PURPOSE
// - AHB-Lite responder at a crossbar/arbiter dst port, fronting a single-port synchronous SRAM.
// - Zero wait states for all legal transfers; reads issue in address phase, writes retire via 1-entry write buffer.
// - Forwards buffered write bytes into read data, so read-after-write is always coherent.
// PARAMETERS
// - W_ADDR  32    AHB address width
// - W_DATA  32    bus/SRAM data width; 32 or 64 only
// - DEPTH   2048  SRAM depth in words; localparam W_SRAM_ADDR = $clog2(DEPTH), W_BYTE = $clog2(W_DATA/8)
// PORTS
// - clk                clock (all state rising-edge)
// - rst_n              reset, asynchronous, active-low
// - ahbls_hready       in   1            global HREADY; transfer sampled when high
// - ahbls_hready_resp  out  1            slave ready response
// - ahbls_hresp        out  1            1 = ERROR
// - ahbls_haddr        in   W_ADDR       byte address
// - ahbls_hwrite       in   1            1 = write
// - ahbls_htrans       in   2            bit1 set = NONSEQ/SEQ (active)
// - ahbls_hsize        in   3            log2 bytes
// - ahbls_hburst/hprot/hmastlock  in 3/4/1  ignored
// - ahbls_hwdata       in   W_DATA       write data (data phase)
// - ahbls_hrdata       out  W_DATA       read data (data phase)
// - sram_addr          out  W_SRAM_ADDR  word address
// - sram_ren           out  1            read strobe; sram_rdata valid next cycle
// - sram_wen           out  W_DATA/8     byte write enables
// - sram_wdata         out  W_DATA       write data
// - sram_rdata         in   W_DATA       read data
// BEHAVIOUR
// - aphase = ahbls_hready & htrans[1]. Word index = haddr[W_BYTE +: W_SRAM_ADDR]; upper bits ignored (aliasing).
// - Byte mask from hsize/haddr low bits: byte 1 lane, half 2 lanes, word all (64b: dword all); captured in aphase.
// - Registered state: dph_read, dph_write, dph_addr, dph_mask, wbuf_{valid,addr,mask,data}, err state.
// - SRAM port priority per cycle: (1) read aphase -> sram_ren=1, sram_addr=haddr word;
//   (2) wbuf_valid -> flush: sram_wen=wbuf_mask, addr/data from wbuf, clear wbuf_valid;
//   (3) write dphase -> direct: sram_wen=dph_mask, sram_addr=dph_addr, sram_wdata=hwdata.
// - Write dphase concurrent with read aphase: hwdata & mask load into wbuf at cycle end.
// - Invariant (assert): wbuf_valid never set at start of a write dphase (write aphase always frees port to flush).
// - Read dphase: hrdata byte k = (wbuf_valid & wbuf_addr==dph_addr & wbuf_mask[k]) ? wbuf byte : sram_rdata byte; else 0.
// - Back-to-back reads hold wbuf indefinitely; forwarding covers it; flush on first non-read-aphase cycle.
// - Legal transfers: hready_resp=1, hresp=0 always; no wait states.
// - Reset (incl. mid-operation): wbuf_valid=0 (pending write discarded), dph_*=0, hready_resp=1, hresp=0,
//   hrdata=0, sram_ren=0, sram_wen=0 until first aphase after release.
// CONFIGURATION
// - AHBL_SRAM_ALIGN_CHECK_EN defined: aphase with haddr not aligned to hsize, or hsize > W_BYTE, gets
//   two-cycle ERROR: cycle1 hready_resp=0/hresp=1, cycle2 hready_resp=1/hresp=1; no SRAM access, no wbuf load.
//   States IDLE -> ERR1 -> ERR2 -> IDLE (ERR2 may accept a new aphase, goes to next state normally).
// - Undefined: no error path, hresp tied 0; misaligned low address bits within the access size are masked off.
// TESTING
// - Write 0xDEADBEEF @0x10 then read @0x10 back-to-back -> read dphase hrdata=0xDEADBEEF (forwarded), zero waits; sram_wen=0xF next idle cycle.
// - Word 0x11223344 @0x0, byte write 0xAB @0x3, read @0x0 -> hrdata=0xAB223344.
// - Buffered write followed by 10 consecutive reads -> sram_wen=0 throughout, every hit forwards; first idle cycle -> sram_wen=mask.
// - Half write 0x5566 @0x22 dphase concurrent with read aphase @0x20 (old 0xFFFFFFFF) -> hrdata=0x5566FFFF.
// - ALIGN_CHECK_EN: word read @0x2 -> (0,1),(1,1) on hready_resp/hresp, sram_ren=0; undefined: returns word @0x0.
// - rst_n low while wbuf_valid -> no sram_wen pulse after release; subsequent read @that addr returns old SRAM data.

Source files
------------

// File: rtl/ahbl_sync_sram_slave.sv
// ahbl_sync_sram_slave
// AHB-Lite responder fronting a single-port synchronous SRAM with zero wait states.
// - Reads are issued to the SRAM during the address phase, so read data is ready in the
//   data phase.
// - Writes go straight to the SRAM when the port is free. A write data phase that coincides
//   with a read address phase is parked in a 1-entry write buffer instead.
// - That buffer is forwarded byte-wise into read data, so read-after-write stays coherent.
// Optional feature (macro AHBL_SRAM_ALIGN_CHECK_EN):
// - A misaligned or oversized transfer gets a two-cycle ERROR response.
// - Without the macro there is no error path, and misaligned low address bits are masked off.

module ahbl_sync_sram_slave #(
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned W_DATA = 32,
    parameter int unsigned DEPTH  = 2048,
    localparam int unsigned W_SRAM_ADDR = $clog2(DEPTH),
    localparam int unsigned W_BYTE      = $clog2(W_DATA / 8),
    localparam int unsigned N_BYTE      = W_DATA / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   ahbls_hready,
    output logic                   ahbls_hready_resp,
    output logic                   ahbls_hresp,
    input  logic [W_ADDR-1:0]      ahbls_haddr,
    input  logic                   ahbls_hwrite,
    input  logic [1:0]             ahbls_htrans,
    input  logic [2:0]             ahbls_hsize,
    input  logic [2:0]             ahbls_hburst,
    input  logic [3:0]             ahbls_hprot,
    input  logic                   ahbls_hmastlock,
    input  logic [W_DATA-1:0]      ahbls_hwdata,
    output logic [W_DATA-1:0]      ahbls_hrdata,

    output logic [W_SRAM_ADDR-1:0] sram_addr,
    output logic                   sram_ren,
    output logic [N_BYTE-1:0]      sram_wen,
    output logic [W_DATA-1:0]      sram_wdata,
    input  logic [W_DATA-1:0]      sram_rdata
);

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------

    // Byte-lane mask for an access of the given size.
    // Oversized accesses are clamped to the full bus width.
    // Low address bits below the access size are ignored.
    function automatic logic [N_BYTE-1:0] calc_mask(input logic [2:0] size,
                                                    input logic [W_BYTE-1:0] lsb);
        int unsigned sz;
        int unsigned nb;
        int unsigned off;
        logic [N_BYTE-1:0] m;
        sz = 32'(size);
        if (sz > W_BYTE) begin
            sz = W_BYTE;
        end
        nb  = 32'd1 << sz;
        off = 32'(lsb) & ~(nb - 32'd1);
        for (int unsigned k = 0; k < N_BYTE; k++) begin
            m[k] = (k >= off) && (k < off + nb);
        end
        return m;
    endfunction

`ifdef AHBL_SRAM_ALIGN_CHECK_EN
    // True when the address is not a multiple of the access size,
    // or the access is wider than the bus.
    function automatic logic is_misaligned(input logic [2:0] size,
                                           input logic [W_BYTE-1:0] lsb);
        logic too_big;
        logic off_grid;
        too_big  = 32'(size) > W_BYTE;
        off_grid = (32'(lsb) & ((32'd1 << size) - 32'd1)) != 32'd0;
        return too_big || off_grid;
    endfunction
`endif

    // ------------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------------

    logic                   aphase;
    logic                   aph_err;
    logic                   aph_ok;
    logic                   read_aph;
    logic                   write_aph;
    logic [W_SRAM_ADDR-1:0] aph_word;
    logic [N_BYTE-1:0]      aph_mask;

    assign aphase = ahbls_hready && ahbls_htrans[1];

`ifdef AHBL_SRAM_ALIGN_CHECK_EN
    assign aph_err = aphase && is_misaligned(ahbls_hsize, ahbls_haddr[W_BYTE-1:0]);
`else
    assign aph_err = 1'b0;
`endif

    assign aph_ok    = aphase && !aph_err;
    assign read_aph  = aph_ok && !ahbls_hwrite;
    assign write_aph = aph_ok && ahbls_hwrite;

    // Upper address bits are dropped, so the SRAM aliases across the address space.
    assign aph_word = ahbls_haddr[W_BYTE +: W_SRAM_ADDR];
    assign aph_mask = calc_mask(ahbls_hsize, ahbls_haddr[W_BYTE-1:0]);

    // These inputs carry nothing this responder needs.
    logic unused_inputs;
    assign unused_inputs = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_htrans[0],
                             ahbls_haddr};

    // ------------------------------------------------------------------------
    // Data-phase and write-buffer state
    // ------------------------------------------------------------------------

    logic                   dph_read;
    logic                   dph_write;
    logic [W_SRAM_ADDR-1:0] dph_addr;
    logic [N_BYTE-1:0]      dph_mask;

    logic                   wbuf_valid;
    logic [W_SRAM_ADDR-1:0] wbuf_addr;
    logic [N_BYTE-1:0]      wbuf_mask;
    logic [W_DATA-1:0]      wbuf_data;

    logic                   wbuf_load;
    logic                   wbuf_flush;

    // A write data phase can only be parked when a read holds the port.
    assign wbuf_load  = read_aph && dph_write;
    assign wbuf_flush = wbuf_valid && !read_aph;

    // Capture the address phase into data-phase state whenever the bus advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph_read  <= 1'b0;
            dph_write <= 1'b0;
            dph_addr  <= '0;
            dph_mask  <= '0;
        end else if (ahbls_hready) begin
            dph_read  <= read_aph;
            dph_write <= write_aph;
            if (aph_ok) begin
                dph_addr <= aph_word;
                dph_mask <= aph_mask;
            end
        end
    end

    // Write buffer: fill from a write data phase that lost the port to a read.
    // Drain on the first cycle without a read address phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbuf_valid <= 1'b0;
            wbuf_addr  <= '0;
            wbuf_mask  <= '0;
            wbuf_data  <= '0;
        end else if (wbuf_load) begin
            wbuf_valid <= 1'b1;
            wbuf_addr  <= dph_addr;
            wbuf_mask  <= dph_mask;
            wbuf_data  <= ahbls_hwdata;
        end else if (wbuf_flush) begin
            wbuf_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // SRAM port arbitration
    // ------------------------------------------------------------------------

    // Port priority: read address phase, then buffer drain, then direct write.
    always_comb begin
        sram_ren   = 1'b0;
        sram_wen   = '0;
        sram_addr  = aph_word;
        sram_wdata = wbuf_data;
        if (read_aph) begin
            sram_ren = 1'b1;
        end else if (wbuf_valid) begin
            sram_wen   = wbuf_mask;
            sram_addr  = wbuf_addr;
            sram_wdata = wbuf_data;
        end else if (dph_write) begin
            sram_wen   = dph_mask;
            sram_addr  = dph_addr;
            sram_wdata = ahbls_hwdata;
        end
    end

    // ------------------------------------------------------------------------
    // Read data with write-buffer forwarding
    // ------------------------------------------------------------------------

    logic fwd_hit;
    assign fwd_hit = wbuf_valid && (wbuf_addr == dph_addr);

    // Merge buffered bytes over SRAM data; drive zero outside read data phases.
    always_comb begin
        ahbls_hrdata = '0;
        if (dph_read) begin
            for (int unsigned k = 0; k < N_BYTE; k++) begin
                if (fwd_hit && wbuf_mask[k]) begin
                    ahbls_hrdata[8*k +: 8] = wbuf_data[8*k +: 8];
                end else begin
                    ahbls_hrdata[8*k +: 8] = sram_rdata[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response generation
    // ------------------------------------------------------------------------

`ifdef AHBL_SRAM_ALIGN_CHECK_EN
    typedef enum logic [1:0] {StIdle, StErr1, StErr2} err_state_e;

    err_state_e err_state;
    logic       hready_resp_q;
    logic       hresp_q;

    // Two-cycle ERROR sequence with registered responses.
    // ERR2 may take a new address phase like IDLE does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_state     <= StIdle;
            hready_resp_q <= 1'b1;
            hresp_q       <= 1'b0;
        end else begin
            case (err_state)
                StIdle, StErr2: begin
                    if (aph_err) begin
                        err_state     <= StErr1;
                        hready_resp_q <= 1'b0;
                        hresp_q       <= 1'b1;
                    end else begin
                        err_state     <= StIdle;
                        hready_resp_q <= 1'b1;
                        hresp_q       <= 1'b0;
                    end
                end
                StErr1: begin
                    err_state     <= StErr2;
                    hready_resp_q <= 1'b1;
                    hresp_q       <= 1'b1;
                end
                default: begin
                    err_state     <= StIdle;
                    hready_resp_q <= 1'b1;
                    hresp_q       <= 1'b0;
                end
            endcase
        end
    end

    assign ahbls_hready_resp = hready_resp_q;
    assign ahbls_hresp       = hresp_q;
`else
    assign ahbls_hready_resp = 1'b1;
    assign ahbls_hresp       = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Checks
    // ------------------------------------------------------------------------

`ifndef SYNTHESIS
    // A write address phase always leaves the port free to drain the buffer.
    // So the buffer is empty whenever a write data phase begins.
    wbuf_empty_at_write_dphase: assert property (
        @(posedge clk) disable iff (!rst_n) dph_write |-> !wbuf_valid
    );
`endif

endmodule
